serial_alu_core: RTL and testbench

Bit-serial ALU execute stage for the toy processor, directly downstream of the per-bit arithmetic extender function.
- Per bit, it applies the extender selection (M, S1, S0, b_i → y_i) and the logic path.
- Arithmetic results come from a single full adder and a carry flip-flop, one operand bit per clock, LSB first.
- Handshake: START launches an operation; a one-cycle DONE reports the result word and its flags.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/serial_alu_bitslice.sv | 49 ++++
 rtl/serial_alu_core.sv | 113 +++++++++++
 tb/tb_serial_alu_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the bit-serial ALU execute stage.
// Select codes are the {S1,S0} pair; their meaning depends on M.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE_S
    } state_t;

    localparam logic [1:0] ARITH_ZERO = 2'b00;
    localparam logic [1:0] ARITH_B    = 2'b01;
    localparam logic [1:0] ARITH_NOTB = 2'b10;
    localparam logic [1:0] ARITH_ONES = 2'b11;

    localparam logic [1:0] LOGIC_AND  = 2'b00;
    localparam logic [1:0] LOGIC_OR   = 2'b01;
    localparam logic [1:0] LOGIC_XOR  = 2'b10;
    localparam logic [1:0] LOGIC_NOTA = 2'b11;

    localparam int unsigned DEFAULT_N = 4;

endpackage

// File: rtl/serial_alu_bitslice.sv
// One bit of the ALU: arithmetic extender feeding a full adder, plus the logic mux.
// In logic mode the carry output is held at 0 so the carry chain stays clear.
module serial_alu_bitslice
    import alu_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c,
    input  logic M,
    input  logic S1,
    input  logic S0,
    output logic f_i,
    output logic c_next
);

    logic [1:0] sel;
    logic       y;

    assign sel = {S1, S0};

    always_comb begin
        y = 1'b0;
        case (sel)
            ARITH_ZERO: y = 1'b0;
            ARITH_B:    y = b_i;
            ARITH_NOTB: y = ~b_i;
            ARITH_ONES: y = 1'b1;
            default:    y = 1'b0;
        endcase
    end

    always_comb begin
        f_i    = 1'b0;
        c_next = 1'b0;
        if (M) begin
            f_i    = a_i ^ y ^ c;
            c_next = (a_i & y) | (a_i & c) | (y & c);
        end else begin
            case (sel)
                LOGIC_AND:  f_i = a_i & b_i;
                LOGIC_OR:   f_i = a_i | b_i;
                LOGIC_XOR:  f_i = a_i ^ b_i;
                LOGIC_NOTA: f_i = ~a_i;
                default:    f_i = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/serial_alu_core.sv
// Bit-serial ALU execute stage: START/DONE handshake, one operand bit per clock, LSB first.
// Result and flags are registered on the completion edge and hold between operations.
module serial_alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         M,
    input  logic         S1,
    input  logic         S0,
    input  logic         C0,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] F,
    output logic         COUT,
    output logic         V,
    output logic         Z
);

    localparam int unsigned CW = $clog2(N);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-2:0]   res_q;
    logic           m_q;
    logic [1:0]     sel_q;
    logic           c_q;
    logic [N-1:0]   f_q;
    logic           cout_q;
    logic           v_q;
    logic           z_q;

    logic           f_bit;
    logic           c_next;
    logic [N-1:0]   word_d;

    serial_alu_bitslice u_slice (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .c      (c_q),
        .M      (m_q),
        .S1     (sel_q[1]),
        .S0     (sel_q[0]),
        .f_i    (f_bit),
        .c_next (c_next)
    );

    // On the last bit, res_q holds the N-1 lower result bits already shifted into place.
    assign word_d = {f_bit, res_q};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            m_q     <= 1'b0;
            sel_q   <= '0;
            c_q     <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        m_q     <= M;
                        sel_q   <= {S1, S0};
                        c_q     <= M & C0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= word_d[N-1:1];
                    c_q   <= c_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        // c_q is the carry into the MSB here, c_next the carry out.
                        f_q     <= word_d;
                        cout_q  <= c_next;
                        v_q     <= c_q ^ c_next;
                        z_q     <= ~|word_d;
                        state_q <= DONE_S;
                    end
                end
                DONE_S: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY = (state_q == SHIFT);
    assign DONE = (state_q == DONE_S);
    assign F    = f_q;
    assign COUT = cout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_alu_core.sv
// Directed and random checks of serial_alu_core (N=4) against an integer-arithmetic reference.
module tb_serial_alu_core;

    localparam int unsigned N = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         M = 1'b0;
    logic         S1 = 1'b0;
    logic         S0 = 1'b0;
    logic         C0 = 1'b0;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] F;
    logic         COUT;
    logic         V;
    logic         Z;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Values the DUT should be holding on F/COUT/V/Z between operations.
    logic [N-1:0] hold_f = '0;
    logic         hold_cout = 1'b0;
    logic         hold_v = 1'b0;
    logic         hold_z = 1'b0;

    serial_alu_core #(.N(N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .M     (M),
        .S1    (S1),
        .S0    (S0),
        .C0    (C0),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .F     (F),
        .COUT  (COUT),
        .V     (V),
        .Z     (Z)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {Z, V, COUT, F[3:0]} from plain integer arithmetic on 4-bit words.
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic m, input logic [1:0] s, input logic c0);
        int unsigned ai, bi, y, sum, low, f, cout, cin_msb, v;
        ai = a;
        bi = b;
        f = 0; cout = 0; v = 0;
        if (m) begin
            case (s)
                2'd0: y = 0;
                2'd1: y = bi;
                2'd2: y = 15 - bi;
                default: y = 15;
            endcase
            sum     = ai + y + c0;
            f       = sum % 16;
            cout    = sum / 16;
            low     = (ai % 8) + (y % 8) + c0;
            cin_msb = low / 8;
            v       = cin_msb ^ cout;
        end else begin
            case (s)
                2'd0: f = ai & bi;
                2'd1: f = ai | bi;
                2'd2: f = ai ^ bi;
                default: f = 15 - ai;
            endcase
        end
        return {(f == 0), v[0], cout[0], f[3:0]};
    endfunction

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic m,
                          input logic [1:0] s, input logic c0, input string tag);
        logic [6:0] e;
        e = model(a, b, m, s, c0);
        @(negedge CLK);
        A = a; B = b; M = m; S1 = s[1]; S0 = s[0]; C0 = c0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        A = 4'($urandom); B = 4'($urandom); M = 1'($urandom);
        S1 = 1'($urandom); S0 = 1'($urandom); C0 = 1'($urandom);
        check({tag, ".busy0"}, 32'(BUSY), 32'd1);
        check({tag, ".done0"}, 32'(DONE), 32'd0);
        for (int unsigned i = 1; i < N; i++) begin
            @(posedge CLK); #1;
            A = 4'($urandom); B = 4'($urandom);
            check({tag, ".busy"}, 32'(BUSY), 32'd1);
            check({tag, ".done_early"}, 32'(DONE), 32'd0);
        end
        check({tag, ".f_hold"}, 32'(F), 32'(hold_f));
        check({tag, ".flags_hold"}, 32'({hold_cout, hold_v, hold_z}), 32'({COUT, V, Z}));
        @(posedge CLK); #1;
        check({tag, ".done"}, 32'(DONE), 32'd1);
        check({tag, ".busy_end"}, 32'(BUSY), 32'd0);
        check({tag, ".F"}, 32'(F), 32'(e[3:0]));
        check({tag, ".COUT"}, 32'(COUT), 32'(e[4]));
        check({tag, ".V"}, 32'(V), 32'(e[5]));
        check({tag, ".Z"}, 32'(Z), 32'(e[6]));
        hold_f = e[3:0]; hold_cout = e[4]; hold_v = e[5]; hold_z = e[6];
        @(posedge CLK); #1;
        check({tag, ".done_fall"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        int unsigned done_cnt;
        int unsigned first_done;
        int unsigned second_done;
        logic [6:0]  e;

        #3;
        check("reset.outs", 32'({BUSY, DONE, F, COUT, V, Z}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_op(4'd5, 4'd3, 1'b1, 2'b01, 1'b0, "add");
        run_op(4'd3, 4'd3, 1'b1, 2'b10, 1'b1, "sub");
        run_op(4'd15, 4'd0, 1'b1, 2'b00, 1'b1, "inc");
        run_op(4'd0, 4'd0, 1'b1, 2'b11, 1'b0, "dec");
        run_op(4'hA, 4'h6, 1'b0, 2'b10, 1'b0, "xor");
        run_op(4'hA, 4'h6, 1'b0, 2'b00, 1'b1, "and");
        run_op(4'hA, 4'h6, 1'b0, 2'b01, 1'b1, "or");
        run_op(4'hA, 4'h6, 1'b0, 2'b11, 1'b1, "nota");
        run_op(4'd7, 4'd1, 1'b1, 2'b01, 1'b0, "add_ovf");
        run_op(4'd8, 4'd1, 1'b1, 2'b10, 1'b1, "sub_ovf");

        // START held high: one DONE per N+2 cycles, each a full operation.
        e = model(4'd9, 4'd9, 1'b1, 2'b01, 1'b0);
        @(negedge CLK);
        A = 4'd9; B = 4'd9; M = 1'b1; S1 = 1'b0; S0 = 1'b1; C0 = 1'b0; START = 1'b1;
        done_cnt = 0; first_done = 0; second_done = 0;
        for (int unsigned cyc = 0; cyc < 2 * N + 4; cyc++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                if (done_cnt == 0) first_done = cyc;
                else if (done_cnt == 1) second_done = cyc;
                done_cnt++;
                check("hold.F", 32'(F), 32'(e[3:0]));
            end
        end
        START = 1'b0;
        check("hold.done_count", done_cnt, 32'd2);
        check("hold.first_latency", first_done, N);
        check("hold.spacing", second_done - first_done, N + 2);
        hold_f = e[3:0]; hold_cout = e[4]; hold_v = e[5]; hold_z = e[6];
        repeat (3) @(posedge CLK);
        #1;
        check("hold.idle", 32'({BUSY, DONE}), 32'd0);

        // Reset in the second SHIFT cycle aborts the operation.
        @(negedge CLK);
        A = 4'd6; B = 4'd2; M = 1'b1; S1 = 1'b0; S0 = 1'b1; C0 = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        check("rst.pre_busy", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst.outs", 32'({BUSY, DONE, F, COUT, V, Z}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        hold_f = '0; hold_cout = 1'b0; hold_v = 1'b0; hold_z = 1'b0;
        done_cnt = 0;
        for (int unsigned cyc = 0; cyc < 2 * N; cyc++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) done_cnt++;
        end
        check("rst.no_done", done_cnt, 32'd0);
        run_op(4'd6, 4'd2, 1'b1, 2'b01, 1'b0, "post_rst");

        for (int unsigned k = 0; k < 20; k++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
